// File: rtl/tlc_signal_monitor.sv
// Lamp-side decoder and safety monitor for the traffic light controller.
// Optional build macro: TLC_MON_FLASH_EN (flash the fail-safe red during a fault).
module tlc_signal_monitor #(
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned MIN_ALLRED = 2,
    parameter int unsigned FLASH_HALF = 3,
    parameter int unsigned CNT_W      = 31
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] highwaySignal,
    input  logic [1:0] farmSignal,
    output logic [2:0] highwayLamps,
    output logic [2:0] farmLamps,
    output logic       fault,
    output logic [2:0] faultCode
);

    localparam logic [1:0] SigGreen  = 2'b00;
    localparam logic [1:0] SigYellow = 2'b01;
    localparam logic [1:0] SigRed    = 2'b10;
    localparam logic [1:0] SigBad    = 2'b11;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    if (FLASH_HALF < 1) begin : gen_bad_flash_half
        $error("FLASH_HALF must be at least 1");
    end
    if (CNT_W < 2) begin : gen_bad_cnt_w
        $error("CNT_W must be at least 2");
    end

    function automatic logic [2:0] decode(input logic [1:0] sig);
        logic [2:0] lamp;
        unique case (sig)
            SigGreen:  lamp = 3'b001;
            SigYellow: lamp = 3'b010;
            default:   lamp = 3'b100;
        endcase
        return lamp;
    endfunction

    // Only G->Y, Y->R, R->G and hold are legal; invalid encodings are reported separately.
    function automatic logic illegal_step(input logic [1:0] prev, input logic [1:0] cur);
        if (prev == SigBad || cur == SigBad) begin
            return 1'b0;
        end
        return (prev == SigGreen  && cur == SigRed)
            || (prev == SigRed    && cur == SigYellow)
            || (prev == SigYellow && cur == SigGreen);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CntMax) ? cnt : cnt + 1'b1;
    endfunction

    // Sample (S) and previous-sample (P) registers
    logic [1:0] hwySampQ, farmSampQ, hwyPrevQ, farmPrevQ;

    // Run-length counters describe the run that ends at P, so they are valid
    // exactly when a transition P->S is being judged.
    logic [CNT_W-1:0] hwyYelCntQ, hwyYelCntD;
    logic [CNT_W-1:0] farmYelCntQ, farmYelCntD;
    logic [CNT_W-1:0] allRedCntQ, allRedCntD;

    logic [2:0] hwyLampQ, farmLampQ;
    logic       faultQ, faultD;
    logic [2:0] faultCodeQ, faultCodeD;
    logic [2:0] violCode;
    logic [2:0] failSafe;

    logic sampAllRed, prevAllRed;
    logic conflict, illegalTrans, shortYellow, invalidEnc, shortClear;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hwySampQ  <= SigRed;
            farmSampQ <= SigRed;
            hwyPrevQ  <= SigRed;
            farmPrevQ <= SigRed;
        end else begin
            hwySampQ  <= highwaySignal;
            farmSampQ <= farmSignal;
            hwyPrevQ  <= hwySampQ;
            farmPrevQ <= farmSampQ;
        end
    end

    assign sampAllRed = hwySampQ[1] & farmSampQ[1];
    assign prevAllRed = hwyPrevQ[1] & farmPrevQ[1];

    always_comb begin
        hwyYelCntD  = '0;
        farmYelCntD = '0;
        allRedCntD  = '0;
        if (hwySampQ == SigYellow) begin
            hwyYelCntD = (hwyPrevQ == SigYellow) ? sat_inc(hwyYelCntQ) : {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (farmSampQ == SigYellow) begin
            farmYelCntD = (farmPrevQ == SigYellow) ? sat_inc(farmYelCntQ)
                                                   : {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (sampAllRed) begin
            allRedCntD = prevAllRed ? sat_inc(allRedCntQ) : {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            hwyYelCntQ  <= '0;
            farmYelCntQ <= '0;
            allRedCntQ  <= CntMax;
        end else begin
            hwyYelCntQ  <= hwyYelCntD;
            farmYelCntQ <= farmYelCntD;
            allRedCntQ  <= allRedCntD;
        end
    end

    always_comb begin
        conflict     = !hwySampQ[1] && !farmSampQ[1];
        illegalTrans = illegal_step(hwyPrevQ, hwySampQ) || illegal_step(farmPrevQ, farmSampQ);
        shortYellow  = (hwyPrevQ == SigYellow && hwySampQ == SigRed
                        && hwyYelCntQ < CNT_W'(MIN_YELLOW))
                    || (farmPrevQ == SigYellow && farmSampQ == SigRed
                        && farmYelCntQ < CNT_W'(MIN_YELLOW));
        invalidEnc   = (hwySampQ == SigBad) || (farmSampQ == SigBad);
        shortClear   = ((hwyPrevQ == SigRed && hwySampQ == SigGreen)
                        || (farmPrevQ == SigRed && farmSampQ == SigGreen))
                    && allRedCntQ < CNT_W'(MIN_ALLRED);

        violCode = 3'd0;
        if (conflict) begin
            violCode = 3'd1;
        end else if (illegalTrans) begin
            violCode = 3'd2;
        end else if (shortYellow) begin
            violCode = 3'd3;
        end else if (invalidEnc) begin
            violCode = 3'd4;
        end else if (shortClear) begin
            violCode = 3'd5;
        end
    end

    // First violation wins; the latch only clears on reset.
    always_comb begin
        faultD     = faultQ;
        faultCodeD = faultCodeQ;
        if (!faultQ && violCode != 3'd0) begin
            faultD     = 1'b1;
            faultCodeD = violCode;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            faultQ     <= 1'b0;
            faultCodeQ <= 3'd0;
            hwyLampQ   <= 3'b100;
            farmLampQ  <= 3'b100;
        end else begin
            faultQ     <= faultD;
            faultCodeQ <= faultCodeD;
            hwyLampQ   <= decode(hwySampQ);
            farmLampQ  <= decode(farmSampQ);
        end
    end

`ifdef TLC_MON_FLASH_EN
    localparam int unsigned FlashPeriod = 2 * FLASH_HALF;
    localparam int unsigned FlashW      = (FlashPeriod > 2) ? $clog2(FlashPeriod) : 1;

    logic [FlashW-1:0] flashCntQ;

    // Phase 0 lines up with the cycle fault first reads 1, so the flash starts lit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            flashCntQ <= '0;
        end else if (!faultQ) begin
            flashCntQ <= '0;
        end else if (flashCntQ == FlashW'(FlashPeriod - 1)) begin
            flashCntQ <= '0;
        end else begin
            flashCntQ <= flashCntQ + 1'b1;
        end
    end

    assign failSafe = {(flashCntQ < FlashW'(FLASH_HALF)), 2'b00};
`else
    assign failSafe = 3'b100;
`endif

    always_comb begin
        highwayLamps = faultQ ? failSafe : hwyLampQ;
        farmLamps    = faultQ ? failSafe : farmLampQ;
        fault        = faultQ;
        faultCode    = faultCodeQ;
    end

endmodule

// File: doc/tlc_signal_monitor.md
# tlc_signal_monitor

Lamp-side decoder and safety monitor for the traffic light controller. It takes the 2-bit encoded `highwaySignal` and `farmSignal` buses driven by the controller FSM and decodes them into one-hot red/yellow/green lamp drives. It also checks every signal sequence against intersection safety rules. On the first violation it latches a fault and forces both approaches to fail-safe red until reset.

## Interface
- `MIN_YELLOW`, default 4: minimum consecutive cycles a yellow must be held before red.
- `MIN_ALLRED`, default 2: minimum consecutive cycles both approaches must be red before either goes green.
- `FLASH_HALF`, default 3: half-period, in cycles, of the fault flash.
- `CNT_W`, default 31: width of the internal duration counters.
- `Clk` input 1: system clock; single clock domain.
- `Rst` input 1: asynchronous, active-high reset.
- `highwaySignal` input 2: encoding is 00 green, 01 yellow, 10 red, 11 invalid.
- `farmSignal` input 2: same encoding as `highwaySignal`.
- `highwayLamps` output 3: {R,Y,G} one-hot lamp drive.
- `farmLamps` output 3: {R,Y,G} one-hot lamp drive.
- `fault` output 1: latched fault flag.
- `faultCode` output 3: cause of the first fault; 0 when no fault.

## Operation
- Sample stage: both input buses are registered every cycle into S. The previous contents of S are held in P.
- Decode:
  - 00 → 001 (G)
  - 01 → 010 (Y)
  - 10 → 100 (R)
  - 11 → 100 (R), and code 4 is flagged.
- Per-approach yellow counter:
  - Counts consecutive cycles in which S is yellow.
  - Loads 1 on the transition into yellow.
  - Saturates at 2^CNT_W−1.
- All-red counter:
  - Counts consecutive cycles in which both approaches in S are red.
  - Loads 1 on entry to all-red.
  - Saturates at 2^CNT_W−1.
- Checks are evaluated on S versus P and the counters. Codes:
  - 1 conflict: neither approach is red.
  - 2 illegal transition: G→R, R→Y, Y→G, or G→Y→G skipped order; only G→Y, Y→R, R→G and hold are legal.
  - 3 short yellow: Y→R with yellow counter < MIN_YELLOW.
  - 4 invalid encoding: S contains 11.
  - 5 short clearance: R→G on either approach with all-red counter < MIN_ALLRED.
- Multiple simultaneous violations: the lowest code is reported.
- Fault latch:
  - `fault` is set on the first violation and holds.
  - `faultCode` is frozen at that first code.
  - Further violations are ignored.
  - Only `Rst` clears the latch.
- While `fault` is 1: both lamp outputs are forced to fail-safe red (see Configuration). Decode and check results are ignored.

## Timing
- Reset values:
  - `highwayLamps` = `farmLamps` = 100
  - `fault` = 0, `faultCode` = 0
  - S and P = both red
  - all-red counter preloaded to 2^CNT_W−1, so the first R→G after reset passes
  - yellow counters = 0
  - flash counter = 0
- Latency: an input change sampled at edge k appears on the lamps at edge k+1. A violation detected on sample k asserts `fault`/`faultCode` at edge k+1, in the same cycle the lamps go fail-safe.
- Boundaries:
  - Yellow held exactly MIN_YELLOW cycles is legal.
  - All-red held exactly MIN_ALLRED cycles is legal.
  - Counters saturate and never wrap.
- Asserting `Rst` mid-sequence or mid-fault returns all outputs to reset values immediately, asynchronously. Deassertion is synchronous to `Clk`; the upstream synchronizer provides this.

## Configuration
- `TLC_MON_FLASH_EN` defined:
  - During a fault, the red lamp of both approaches alternates on/off.
  - On for FLASH_HALF cycles starting in the cycle `fault` asserts, then off for FLASH_HALF cycles, repeating.
  - Yellow and green stay 0.
- `TLC_MON_FLASH_EN` not defined:
  - During a fault, both approaches show steady 100.
  - The flash counter is not built.

## Test plan
Parameters for all tests: MIN_YELLOW=4, MIN_ALLRED=2, FLASH_HALF=3.

- Legal cycle: highway G/farm R → highway Y held 4 cycles → R/R held 2 cycles → farm G.
  - Lamps follow with 1-cycle latency.
  - `fault` stays 0.
  - After reset, highway goes G immediately with no fault.
- Both approaches green (00/00) for one cycle.
  - `fault`=1 and `faultCode`=1 one edge later.
  - Lamps go fail-safe.
- Highway Y held 3 cycles, then R.
  - `faultCode`=3.
  - Repeat with 4 cycles: no fault.
- R/R held 1 cycle, then farm G.
  - `faultCode`=5.
- Farm bus 11 together with a G→R highway jump.
  - `faultCode`=4 is not reported; the lower code 2 wins.
  - A later conflict does not change `faultCode`.
- With `TLC_MON_FLASH_EN` after a fault:
  - Lamps read 100 for 3 cycles, then 000 for 3 cycles, repeating.
  - Without the macro: steady 100.
  - `Rst` pulse mid-flash clears to reset values immediately.
